pipe_mem_arbiter: RTL and testbench

//   Shares one single-port, variable-latency unified memory between the pipeline's

---
 rtl/pipe_mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_pipe_mem_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_mem_arbiter
//  Description : Arbitrates one single-port, variable-latency unified memory
//                between the fetch stage (IF) and the memory stage (MEM).
//                One transaction at a time, memory bus driven from registers,
//                MEM has priority bounded by a fairness streak counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_mem_arbiter #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_DATA_STREAK = 2
) (
  input  logic              CLK,
  input  logic              RST,
  // fetch side
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  // data side
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_valid,
  output logic [DATA_W-1:0] dm_rdata,
  // memory bus
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  // hazard unit
  output logic              stall_if,
  output logic              stall_mem
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DATA  = 2'd2
  } state_t;

  // Streak counter saturates at 15; the configured limit must fit that range.
  localparam logic [3:0] C_MAX_STREAK = 4'(MAX_DATA_STREAK);
  localparam logic [3:0] C_STREAK_SAT = 4'hF;

  state_t              state_q,     state_d;
  logic [3:0]          streak_q,    streak_d;
  logic                mem_req_q,   mem_req_d;
  logic                mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic                w_grant_data;
  logic                w_done;

  // MEM wins unless fetch is waiting and MEM has used up its streak allowance.
  assign w_grant_data = dm_req & (~if_req | (streak_q < C_MAX_STREAK));
  // Completion is only meaningful while a transaction is actually in flight.
  assign w_done       = (state_q != S_IDLE) & mem_ready;

  // State and memory-bus registers; reset abandons any access in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      streak_q    <= 4'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Next-state logic: grant from IDLE, hold the bus until mem_ready.
  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (w_grant_data) begin
          state_d     = S_DATA;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          // Only MEM grants that make fetch wait count towards the streak.
          if (if_req) begin
            streak_d = (streak_q == C_STREAK_SAT) ? C_STREAK_SAT : streak_q + 4'd1;
          end else begin
            streak_d = 4'd0;
          end
        end else if (if_req) begin
          state_d    = S_FETCH;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr;
          streak_d   = 4'd0;
        end
      end
      S_FETCH, S_DATA: begin
        if (mem_ready) begin
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end
      end
      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  assign if_valid  = w_done & (state_q == S_FETCH);
  assign dm_valid  = w_done & (state_q == S_DATA);
  // Read data is forced to zero outside the completion cycle.
  assign if_rdata  = if_valid ? mem_rdata : '0;
  assign dm_rdata  = dm_valid ? mem_rdata : '0;

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  assign stall_if  = if_req & ~if_valid;
  assign stall_mem = dm_req & ~dm_valid;

endmodule
`default_nettype wire

// File: tb/tb_pipe_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_mem_arbiter
//  Description : Self-checking bench for pipe_mem_arbiter with a queue of
//                expected transactions popped on each completion pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic        dm_valid;
  logic [31:0] dm_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        stall_if;
  logic        stall_mem;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic        is_data;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];

  pipe_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DATA_STREAK(2)) dut (
    .CLK(CLK), .RST(RST),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_valid(dm_valid), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; if_req = 1'b1; dm_req = 1'b1; mem_ready = 1'b1;
    dm_addr = 32'h55; dm_wdata = 32'h66; mem_rdata = 32'h77;
    tick();
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL rst_mem_req got %0h want 0", mem_req); end
      vectors++; if (if_valid !== 1'b0 || dm_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got if=%0h dm=%0h want 0 0", if_valid, dm_valid); end
      vectors++; if (stall_if !== 1'b1 || stall_mem !== 1'b1) begin miscompares++; $display("FAIL rst_stall got if=%0h mem=%0h want 1 1", stall_if, stall_mem); end
      vectors++; if (mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin miscompares++; $display("FAIL rst_bus got we=%0h addr=%h wdata=%h want 0 0 0", mem_we, mem_addr, mem_wdata); end
      vectors++; if (if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin miscompares++; $display("FAIL rst_rdata got if=%h dm=%h want 0 0", if_rdata, dm_rdata); end
      tick();
    end
    RST = 1'b0; if_req = 1'b0; dm_req = 1'b0; mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_fetch();
    exp_t e;
    if_req = 1'b1; if_addr = 32'h10; mem_ready = 1'b1; mem_rdata = 32'h00500093;
    exp_q.push_back('{1'b0, 1'b0, 32'h10, 32'h0, 32'h00500093});
    @(negedge CLK);
    vectors++; if (mem_req !== 1'b0 || if_valid !== 1'b0) begin miscompares++; $display("FAIL fetch_c1 got req=%0h valid=%0h want 0 0", mem_req, if_valid); end
    vectors++; if (stall_if !== 1'b1) begin miscompares++; $display("FAIL fetch_c1_stall got %0h want 1", stall_if); end
    tick();
    @(negedge CLK);
    vectors++; if (mem_req !== 1'b1 || if_valid !== 1'b1 || dm_valid !== 1'b0) begin miscompares++; $display("FAIL fetch_c2 got req=%0h ifv=%0h dmv=%0h want 1 1 0", mem_req, if_valid, dm_valid); end
    if (exp_q.size() == 0) begin
      vectors++; miscompares++; $display("FAIL fetch_sb got empty queue want entry");
    end else begin
      e = exp_q.pop_front();
      vectors++; if (mem_addr !== e.addr || mem_we !== e.we) begin miscompares++; $display("FAIL fetch_bus got addr=%h we=%0h want %h %0h", mem_addr, mem_we, e.addr, e.we); end
      vectors++; if (if_rdata !== e.rdata) begin miscompares++; $display("FAIL fetch_rdata got %h want %h", if_rdata, e.rdata); end
    end
    vectors++; if (stall_if !== 1'b0) begin miscompares++; $display("FAIL fetch_c2_stall got %0h want 0", stall_if); end
    tick();
    if_req = 1'b0;
    @(negedge CLK);
    vectors++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || if_valid !== 1'b0) begin miscompares++; $display("FAIL fetch_idle got req=%0h we=%0h v=%0h want 0 0 0", mem_req, mem_we, if_valid); end
    tick();
  endtask

  task automatic test_priority();
    exp_t e;
    if_req = 1'b1; if_addr = 32'h20; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
    mem_ready = 1'b1; mem_rdata = 32'hA5A50001;
    exp_q.push_back('{1'b1, 1'b0, 32'h100, 32'h0, 32'hA5A50001});
    exp_q.push_back('{1'b0, 1'b0, 32'h20, 32'h0, 32'h00001234});
    @(negedge CLK);
    vectors++; if (stall_if !== 1'b1 || stall_mem !== 1'b1 || mem_req !== 1'b0) begin miscompares++; $display("FAIL prio_c1 got sif=%0h smem=%0h req=%0h want 1 1 0", stall_if, stall_mem, mem_req); end
    tick();
    @(negedge CLK);
    e = exp_q.pop_front();
    vectors++; if (dm_valid !== 1'b1 || if_valid !== 1'b0) begin miscompares++; $display("FAIL prio_c2_valid got dm=%0h if=%0h want 1 0", dm_valid, if_valid); end
    vectors++; if (mem_addr !== e.addr || mem_we !== e.we || dm_rdata !== e.rdata) begin miscompares++; $display("FAIL prio_c2_data got addr=%h we=%0h rd=%h want %h %0h %h", mem_addr, mem_we, dm_rdata, e.addr, e.we, e.rdata); end
    vectors++; if (stall_if !== 1'b1 || stall_mem !== 1'b0 || if_rdata !== 32'h0) begin miscompares++; $display("FAIL prio_c2_stall got sif=%0h smem=%0h ifrd=%h want 1 0 0", stall_if, stall_mem, if_rdata); end
    tick();
    dm_req = 1'b0; mem_rdata = 32'h00001234;
    @(negedge CLK);
    vectors++; if (mem_req !== 1'b0 || if_valid !== 1'b0 || stall_if !== 1'b1) begin miscompares++; $display("FAIL prio_c3 got req=%0h ifv=%0h sif=%0h want 0 0 1", mem_req, if_valid, stall_if); end
    tick();
    @(negedge CLK);
    e = exp_q.pop_front();
    vectors++; if (if_valid !== 1'b1 || if_rdata !== e.rdata || mem_addr !== e.addr) begin miscompares++; $display("FAIL prio_c4 got v=%0h rd=%h addr=%h want 1 %h %h", if_valid, if_rdata, mem_addr, e.rdata, e.addr); end
    tick();
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_fairness();
    exp_t e;
    logic order[6];
    order = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 6; k++)
      exp_q.push_back('{order[k], 1'b0, order[k] ? 32'h140 : 32'h40, 32'h0, 32'h0});
    if_req = 1'b1; if_addr = 32'h40; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h140; mem_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      mem_rdata = $urandom;
      @(negedge CLK);
      if (if_valid === 1'b1 || dm_valid === 1'b1) begin
        e = exp_q.pop_front();
        vectors++; if (dm_valid !== e.is_data || if_valid !== !e.is_data) begin miscompares++; $display("FAIL fair_order got dm=%0h if=%0h want dm=%0h", dm_valid, if_valid, e.is_data); end
        vectors++; if (mem_addr !== e.addr) begin miscompares++; $display("FAIL fair_addr got %h want %h", mem_addr, e.addr); end
        vectors++; if ((e.is_data ? dm_rdata : if_rdata) !== mem_rdata || (e.is_data ? if_rdata : dm_rdata) !== 32'h0) begin miscompares++; $display("FAIL fair_rdata got if=%h dm=%h want data %h on dm=%0h", if_rdata, dm_rdata, mem_rdata, e.is_data); end
      end
      if (exp_q.size() == 0) begin if_req = 1'b0; dm_req = 1'b0; end
      tick();
    end
    if (exp_q.size() != 0) begin
      vectors++; miscompares++; $display("FAIL fair_timeout got %0d pending want 0", exp_q.size());
      exp_q.delete();
    end
    if_req = 1'b0; dm_req = 1'b0; mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_store_wait();
    exp_t e;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'hDEADBEEF; mem_ready = 1'b0;
    exp_q.push_back('{1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 32'h0});
    @(negedge CLK);
    vectors++; if (mem_req !== 1'b0 || stall_mem !== 1'b1) begin miscompares++; $display("FAIL st_c1 got req=%0h stall=%0h want 0 1", mem_req, stall_mem); end
    tick();
    for (int w = 0; w < 3; w++) begin
      if (w == 0) begin dm_addr = 32'hBAD; dm_wdata = 32'h12345678; dm_we = 1'b0; end
      @(negedge CLK);
      vectors++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h200 || mem_wdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL st_hold%0d got req=%0h we=%0h addr=%h wd=%h want 1 1 00000200 deadbeef", w, mem_req, mem_we, mem_addr, mem_wdata); end
      vectors++; if (stall_mem !== 1'b1 || dm_valid !== 1'b0) begin miscompares++; $display("FAIL st_wait%0d got stall=%0h v=%0h want 1 0", w, stall_mem, dm_valid); end
      tick();
    end
    mem_ready = 1'b1; mem_rdata = 32'hFFFF0000;
    @(negedge CLK);
    e = exp_q.pop_front();
    vectors++; if (dm_valid !== 1'b1 || mem_req !== 1'b1 || stall_mem !== 1'b0) begin miscompares++; $display("FAIL st_done got v=%0h req=%0h stall=%0h want 1 1 0", dm_valid, mem_req, stall_mem); end
    vectors++; if (mem_addr !== e.addr || mem_wdata !== e.wdata || mem_we !== e.we) begin miscompares++; $display("FAIL st_bus got addr=%h wd=%h we=%0h want %h %h %0h", mem_addr, mem_wdata, mem_we, e.addr, e.wdata, e.we); end
    tick();
    dm_req = 1'b0; mem_ready = 1'b0;
    @(negedge CLK);
    vectors++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || dm_valid !== 1'b0 || dm_rdata !== 32'h0) begin miscompares++; $display("FAIL st_idle got req=%0h we=%0h v=%0h rd=%h want 0 0 0 0", mem_req, mem_we, dm_valid, dm_rdata); end
    tick();
  endtask

  task automatic test_drop_req();
    exp_t e;
    if_req = 1'b1; if_addr = 32'h80; mem_ready = 1'b0;
    exp_q.push_back('{1'b0, 1'b0, 32'h80, 32'h0, 32'h00000013});
    tick();
    if_req = 1'b0; if_addr = 32'h999;
    @(negedge CLK);
    vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'h80 || stall_if !== 1'b0) begin miscompares++; $display("FAIL drop_wait got req=%0h addr=%h stall=%0h want 1 00000080 0", mem_req, mem_addr, stall_if); end
    tick();
    mem_ready = 1'b1; mem_rdata = 32'h00000013;
    @(negedge CLK);
    e = exp_q.pop_front();
    vectors++; if (if_valid !== 1'b1 || if_rdata !== e.rdata || mem_addr !== e.addr) begin miscompares++; $display("FAIL drop_done got v=%0h rd=%h addr=%h want 1 %h %h", if_valid, if_rdata, mem_addr, e.rdata, e.addr); end
    tick();
    mem_ready = 1'b0;
    @(negedge CLK);
    vectors++; if (mem_req !== 1'b0 || if_valid !== 1'b0) begin miscompares++; $display("FAIL drop_idle got req=%0h v=%0h want 0 0", mem_req, if_valid); end
    tick();
  endtask

  task automatic test_reset_mid();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300; mem_ready = 1'b0;
    exp_q.push_back('{1'b1, 1'b0, 32'h300, 32'h0, 32'h0});
    tick();
    @(negedge CLK);
    vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'h300) begin miscompares++; $display("FAIL rmid_busy got req=%0h addr=%h want 1 00000300", mem_req, mem_addr); end
    tick();
    RST = 1'b1; dm_req = 1'b0;
    exp_q.delete();
    tick();
    RST = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h77;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      vectors++; if (mem_req !== 1'b0 || dm_valid !== 1'b0 || if_valid !== 1'b0 || dm_rdata !== 32'h0) begin miscompares++; $display("FAIL rmid_after%0d got req=%0h dmv=%0h ifv=%0h rd=%h want 0 0 0 0", i, mem_req, dm_valid, if_valid, dm_rdata); end
      tick();
    end
    mem_ready = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_fairness();
    test_store_wait();
    test_drop_req();
    test_reset_mid();
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL sb_drain got %0d pending want 0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
